// File: rtl/register_dump_reader.sv
// Register bank dump sequencer: walks an address range through one read
// port and streams (address, data) pairs out over a valid/ready handshake.
module register_dump_reader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] firstAddress_i,
   input  logic [ADDR_WIDTH-1:0] lastAddress_i,
   output logic [ADDR_WIDTH-1:0] readAddress_o,
   input  logic [DATA_WIDTH-1:0] readData_i,
   output logic                  outValid_o,
   input  logic                  outReady_i,
   output logic [ADDR_WIDTH-1:0] outAddress_o,
   output logic [DATA_WIDTH-1:0] outData_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [ADDR_WIDTH-1:0] ptr_d;
   logic [ADDR_WIDTH-1:0] last_q;
   logic [ADDR_WIDTH-1:0] out_addr_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  valid_q;
   logic                  busy_q;
   logic                  done_q;

   // Natural wrap past the top address gives the modulo range walk.
   assign ptr_d = ptr_q + ADDR_WIDTH'(1);

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         last_q     <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // The done cycle is still the tail of the previous dump.
               if (start_i && !done_q) begin
                  ptr_q   <= firstAddress_i;
                  last_q  <= lastAddress_i;
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               out_data_q <= readData_i;
               out_addr_q <= ptr_q;
               valid_q    <= 1'b1;
               state_q    <= SEND;
            end
            SEND: begin
               if (outReady_i) begin
                  valid_q <= 1'b0;
                  if (ptr_q == last_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     ptr_q   <= ptr_d;
                     state_q <= FETCH;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign readAddress_o = ptr_q;
   assign outValid_o    = valid_q;
   assign outAddress_o  = out_addr_q;
   assign outData_o     = out_data_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_register_dump_reader.sv
// Directed and randomized dumps checked against an address-range model
// and a bank array held in the bench.
module tb_register_dump_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  first;
   logic [4:0]  last;
   logic [4:0]  readAddress;
   logic [31:0] readData;
   logic        outValid;
   logic        outReady;
   logic [4:0]  outAddress;
   logic [31:0] outData;
   logic        busy;
   logic        done;

   logic [31:0] bank [32];
   bit          wr_armed;

   int checks;
   int errors;

   register_dump_reader #(
      .ADDR_WIDTH(5),
      .DATA_WIDTH(32)
   ) dut (
      .clock_i       (clk),
      .reset_i       (rst_n),
      .start_i       (start),
      .firstAddress_i(first),
      .lastAddress_i (last),
      .readAddress_o (readAddress),
      .readData_i    (readData),
      .outValid_o    (outValid),
      .outReady_i    (outReady),
      .outAddress_o  (outAddress),
      .outData_o     (outData),
      .busy_o        (busy),
      .done_o        (done)
   );

   assign readData = bank[readAddress];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
      @(negedge clk);
      start = 1'b1;
      first = f;
      last  = l;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_no_valid", 32'(outValid), 32'd0);
      chk("fetch_addr", 32'(readAddress), 32'(f));
   endtask

   // Consumes the dump of f..l (wrapping); returns at the done cycle, or
   // early when word index stop_at is presented (left unaccepted).
   task automatic expect_words(input logic [4:0] f, input logic [4:0] l,
                               input int pct, input int stall,
                               input bit noisy, input int stop_at,
                               input int exp_cycles);
      logic [4:0] span;
      logic [4:0] ea;
      int n;
      int got;
      int cyc;
      int nvalid;
      bit pend;
      bit rdy;
      span   = l - f;
      n      = int'(span) + 1;
      got    = 0;
      cyc    = 0;
      nvalid = 0;
      pend   = 1'b0;
      while (got < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (pend) chk("hold_valid", 32'(outValid), 32'd1);
         pend = 1'b0;
         if (wr_armed && busy && !outValid && readAddress == 5'd4) begin
            bank[5]  = 32'hCAFE0005;
            wr_armed = 1'b0;
         end
         if (outValid) begin
            ea = f + 5'(got);
            if (got == stop_at) begin
               outReady = 1'b0;
               return;
            end
            chk("word_addr", 32'(outAddress), 32'(ea));
            chk("word_data", outData, bank[ea]);
            chk("word_busy", 32'(busy), 32'd1);
            rdy = (nvalid >= stall) && ($urandom_range(0, 99) < pct);
            nvalid++;
            outReady = rdy;
            pend = !rdy;
            if (rdy) got++;
         end else begin
            outReady = 1'($urandom_range(0, 1));
         end
         if (noisy) begin
            start = (got < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            first = 5'($urandom_range(0, 31));
            last  = 5'($urandom_range(0, 31));
         end
      end
      chk("word_count", 32'(got), 32'(n));
      if (exp_cycles > 0) chk("cycles", 32'(cyc), 32'(exp_cycles));
      @(negedge clk);
      outReady = 1'b0;
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_valid", 32'(outValid), 32'd0);
   endtask

   task automatic done_end();
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_valid", 32'(outValid), 32'd0);
   endtask

   initial begin
      logic [4:0] rf;
      logic [4:0] rl;
      checks   = 0;
      errors   = 0;
      wr_armed = 1'b0;
      start    = 1'b0;
      first    = '0;
      last     = '0;
      outReady = 1'b0;
      for (int i = 0; i < 32; i++) bank[i] = 32'(i * 17);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(outValid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_oaddr", 32'(outAddress), 32'd0);
      chk("rst_odata", outData, 32'd0);
      chk("rst_raddr", 32'(readAddress), 32'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // Full bank, consumer always ready: one word per two cycles.
      start_dump(5'd0, 5'd31);
      expect_words(5'd0, 5'd31, 100, 0, 1'b0, -1, 63);
      done_end();

      // Wrapping range; start held high through the done cycle.
      start_dump(5'd30, 5'd1);
      expect_words(5'd30, 5'd1, 100, 0, 1'b0, -1, 7);
      start = 1'b1;
      first = 5'd9;
      last  = 5'd9;
      @(negedge clk);
      chk("start_at_done_ignored", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("start_after_done", 32'(busy), 32'd1);
      chk("fetch_addr", 32'(readAddress), 32'd9);
      expect_words(5'd9, 5'd9, 100, 0, 1'b0, -1, 1);
      done_end();

      // Single word with a five-cycle stall.
      bank[7] = 32'hDEADBEEF;
      start_dump(5'd7, 5'd7);
      expect_words(5'd7, 5'd7, 100, 5, 1'b0, -1, 6);
      done_end();

      // Start noise during a dump is ignored.
      start_dump(5'd0, 5'd3);
      expect_words(5'd0, 5'd3, 70, 0, 1'b1, -1, 0);
      done_end();
      repeat (3) begin
         @(negedge clk);
         chk("no_restart", 32'(busy), 32'd0);
      end

      // Reset during SEND of word 2.
      start_dump(5'd0, 5'd3);
      expect_words(5'd0, 5'd3, 100, 0, 1'b0, 2, 0);
      chk("pre_reset_valid", 32'(outValid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(outValid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_odata", outData, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start_dump(5'd0, 5'd1);
      expect_words(5'd0, 5'd1, 100, 0, 1'b0, -1, 3);
      done_end();

      // Bank written while address 4 is being fetched.
      bank[5]  = 32'h11111111;
      wr_armed = 1'b1;
      start_dump(5'd2, 5'd6);
      expect_words(5'd2, 5'd6, 100, 0, 1'b0, -1, 9);
      chk("late_write_seen", bank[5], 32'hCAFE0005);
      done_end();

      // Random banks, ranges and consumer back-pressure.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 32; i++) bank[i] = $urandom;
         rf = 5'($urandom_range(0, 31));
         rl = 5'($urandom_range(0, 31));
         start_dump(rf, rl);
         expect_words(rf, rl, 30 + int'($urandom_range(0, 70)), 0,
                      1'($urandom_range(0, 1)), -1, 0);
         done_end();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
